// File: rtl/solar_pkg.sv
// Shared definitions for the solar array: panel state encoding and default widths.
package solar_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HARVEST = 2'd2,
    ST_FAULT   = 2'd3
  } panel_state_e;

  localparam int DEF_ANGLE_W     = 16;
  localparam int DEF_SUN_W       = 5;
  localparam int DEF_POWER_CONST = 120;

endpackage : solar_pkg

// File: rtl/solar_array_if.sv
// Bundle of per-panel controls and array status between controller and solar array.
interface solar_array_if
  import solar_pkg::*;
#(
  parameter int N_PANELS = 4,
  parameter int ANGLE_W  = DEF_ANGLE_W,
  parameter int SUN_W    = DEF_SUN_W,
  parameter int POWER_W  = 16,
  parameter int ENERGY_W = 32
);
  logic [N_PANELS-1:0]         en;
  logic [N_PANELS-1:0]         fault;
  logic                        clr_energy;
  logic [SUN_W-1:0]            sun;
  logic [2*N_PANELS-1:0]       state;
  logic [ANGLE_W*N_PANELS-1:0] angle;
  logic [POWER_W-1:0]          power_total;
  logic [ENERGY_W-1:0]         energy;

  modport master (
    output en, fault, clr_energy,
    input  sun, state, angle, power_total, energy
  );

  modport slave (
    input  en, fault, clr_energy,
    output sun, state, angle, power_total, energy
  );
endinterface : solar_array_if

// File: rtl/solar_panel_fsm.sv
// One tracking panel: state machine, wrapping angle and fault recovery hold counter.
module solar_panel_fsm
  import solar_pkg::*;
#(
  parameter int ANGLE_W     = DEF_ANGLE_W,
  parameter int ANGLE_INIT  = 16384,
  parameter int ANGLE_DELTA = 2447,
  parameter int FAULT_HOLD  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fault,
  input  logic               day,
  output logic [1:0]         state_o,
  output logic [ANGLE_W-1:0] angle_o
);
  localparam int CNT_W = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FAULT_HOLD - 1);
  localparam logic [ANGLE_W-1:0] STEP     = ANGLE_W'(ANGLE_DELTA);

  panel_state_e       state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next state: fault beats enable, enable beats the day/night edge.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (fault) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_LOAD;
        end else if (en) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_TRACK: begin
        angle_d = angle_q + STEP;
        if (fault) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_LOAD;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (day) begin
          state_d = ST_HARVEST;
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_HARVEST: begin
        angle_d = angle_q - STEP;
        if (fault) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_LOAD;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (!day) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_HARVEST;
        end
      end
      ST_FAULT: begin
        // Residency extends in whole hold periods while the fault persists.
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (fault) begin
          cnt_d = CNT_LOAD;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Panel state, angle and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      angle_q <= ANGLE_W'(ANGLE_INIT);
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign angle_o = angle_q;
endmodule : solar_panel_fsm

// File: rtl/solar_array.sv
// Array of tracking panels sharing one day/night timer, with total power and saturating energy.
module solar_array
  import solar_pkg::*;
#(
  parameter int N_PANELS    = 4,
  parameter int ANGLE_W     = DEF_ANGLE_W,
  parameter int ANGLE_INIT  = 16384,
  parameter int ANGLE_DELTA = 2447,
  parameter int SUN_W       = DEF_SUN_W,
  parameter int POWER_CONST = DEF_POWER_CONST,
  parameter int POWER_W     = 16,
  parameter int ENERGY_W    = 32,
  parameter int FAULT_HOLD  = 8
) (
  input logic           clk,
  input logic           rst,
  solar_array_if.slave  bus
);
  localparam int SUM_W = ((ENERGY_W > POWER_W) ? ENERGY_W : POWER_W) + 1;

  logic [SUN_W-1:0]            sun_q, sun_d;
  logic [ENERGY_W-1:0]         energy_q, energy_d;
  logic [2*N_PANELS-1:0]       state_s;
  logic [ANGLE_W*N_PANELS-1:0] angle_s;
  logic [POWER_W-1:0]          power_s;
  logic [SUM_W-1:0]            sum_s;
  logic                        day_s;

  assign day_s = sun_q[SUN_W-1];

  for (genvar i = 0; i < N_PANELS; i++) begin : g_panel
    solar_panel_fsm #(
      .ANGLE_W    (ANGLE_W),
      .ANGLE_INIT (ANGLE_INIT),
      .ANGLE_DELTA(ANGLE_DELTA),
      .FAULT_HOLD (FAULT_HOLD)
    ) u_panel (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en[i]),
      .fault  (bus.fault[i]),
      .day    (day_s),
      .state_o(state_s[2*i +: 2]),
      .angle_o(angle_s[ANGLE_W*i +: ANGLE_W])
    );
  end

  // Power and energy next-value: sum over harvesting panels, then saturating add.
  always_comb begin
    power_s = {POWER_W{1'b0}};
    for (int i = 0; i < N_PANELS; i++) begin
      if (state_s[2*i +: 2] == ST_HARVEST) begin
        power_s = power_s + POWER_W'(POWER_CONST);
      end else begin
        power_s = power_s;
      end
    end
    sun_d = sun_q + {{(SUN_W-1){1'b0}}, 1'b1};
    sum_s = SUM_W'(energy_q) + SUM_W'(power_s);
    if (bus.clr_energy) begin
      energy_d = {ENERGY_W{1'b0}};
    end else if (|sum_s[SUM_W-1:ENERGY_W]) begin
      energy_d = {ENERGY_W{1'b1}};
    end else begin
      energy_d = sum_s[ENERGY_W-1:0];
    end
  end

  // Shared sun timer and energy accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sun_q    <= {SUN_W{1'b0}};
      energy_q <= {ENERGY_W{1'b0}};
    end else begin
      sun_q    <= sun_d;
      energy_q <= energy_d;
    end
  end

  assign bus.sun         = sun_q;
  assign bus.state       = state_s;
  assign bus.angle       = angle_s;
  assign bus.power_total = power_s;
  assign bus.energy      = energy_q;
endmodule : solar_array

// File: tb/tb_solar_array.sv
// Directed bench for solar_array: a default array, a narrow-energy array and a near-wrap-angle array run in lockstep.
module tb_solar_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cur;
  int   n;

  always #5 clk = ~clk;

  solar_array_if #(.N_PANELS(4), .ANGLE_W(16), .SUN_W(5), .POWER_W(16), .ENERGY_W(32)) m_if ();
  solar_array_if #(.N_PANELS(4), .ANGLE_W(16), .SUN_W(5), .POWER_W(16), .ENERGY_W(10)) s_if ();
  solar_array_if #(.N_PANELS(4), .ANGLE_W(16), .SUN_W(5), .POWER_W(16), .ENERGY_W(32)) w_if ();

  solar_array #(.ENERGY_W(32)) u_main (.clk(clk), .rst(rst), .bus(m_if));
  solar_array #(.ENERGY_W(10)) u_sat  (.clk(clk), .rst(rst), .bus(s_if));
  solar_array #(.ANGLE_INIT(65000)) u_wrap (.clk(clk), .rst(rst), .bus(w_if));

  typedef struct {
    int         edge_n;
    logic [7:0] st;
    int         ang;
    int         pwr;
    int         en_m;
    int         en_s;
    int         ang_w;
    int         sun;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic set_in(input logic [3:0] e, input logic [3:0] f);
    m_if.en = e; s_if.en = e; w_if.en = e;
    m_if.fault = f; s_if.fault = f; w_if.fault = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(4'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] pst(input int i);
    return m_if.state[2*i +: 2];
  endfunction

  function automatic logic [15:0] pang(input int i);
    return m_if.angle[16*i +: 16];
  endfunction

  initial begin
    m_if.clr_energy = 1'b0; s_if.clr_energy = 1'b0; w_if.clr_energy = 1'b0;
    set_in(4'h0, 4'h0);
    //                edge  state  ang0   pwr  e_main e_sat ang_wrap sun
    vecs[0] = '{ 0, 8'h00, 16384,   0,    0,    0, 65000,  0};
    vecs[1] = '{ 1, 8'h55, 16384,   0,    0,    0, 65000,  1};
    vecs[2] = '{ 2, 8'h55, 18831,   0,    0,    0, (65000 + 2447) % 65536, 2};
    vecs[3] = '{16, 8'h55, 53089,   0,    0,    0, 36169, 16};
    vecs[4] = '{17, 8'hAA, 55536, 480,    0,    0, 38616, 17};
    vecs[5] = '{18, 8'hAA, 53089, 480,  480,  480, 36169, 18};
    vecs[6] = '{32, 8'hAA, 18831, 480, 7200, 1023,  1911,  0};
    vecs[7] = '{33, 8'h55, 16384,   0, 7680, 1023, 65000,  1};
    vecs[8] = '{34, 8'h55, 18831,   0, 7680, 1023,  1911,  2};

    // Daily cycle on all three arrays.
    do_reset();
    set_in(4'hF, 4'h0);
    cur = 0;
    for (int v = 0; v < 9; v++) begin
      while (cur < vecs[v].edge_n) begin
        tick();
        cur++;
      end
      check($sformatf("state@%0d", cur), 32'(m_if.state), 32'(vecs[v].st));
      check($sformatf("angle0@%0d", cur), 32'(pang(0)), vecs[v].ang);
      check($sformatf("angle3@%0d", cur), 32'(pang(3)), vecs[v].ang);
      check($sformatf("power@%0d", cur), 32'(m_if.power_total), vecs[v].pwr);
      check($sformatf("energy@%0d", cur), m_if.energy, vecs[v].en_m);
      check($sformatf("sat_energy@%0d", cur), 32'(s_if.energy), vecs[v].en_s);
      check($sformatf("wrap_angle0@%0d", cur), 32'(w_if.angle[15:0]), vecs[v].ang_w);
      check($sformatf("sun@%0d", cur), 32'(m_if.sun), vecs[v].sun);
    end

    // Clear of a saturated accumulator.
    s_if.clr_energy = 1'b1;
    tick(); cur++;
    s_if.clr_energy = 1'b0;
    check("clr_energy", 32'(s_if.energy), 32'd0);

    // Disable one panel during HARVEST.
    while (cur < 50) begin
      tick();
      cur++;
    end
    check("pre_disable_state", 32'(m_if.state), 32'h0000_00AA);
    set_in(4'b1011, 4'h0);
    tick(); cur++;
    check("dis_state2", 32'(pst(2)), 32'd0);
    check("dis_angle2", 32'(pang(2)), 32'd50642);
    check("dis_power", 32'(m_if.power_total), 32'd360);
    check("dis_state0", 32'(pst(0)), 32'd2);
    tick(); cur++;
    check("dis_angle2_hold", 32'(pang(2)), 32'd50642);
    check("dis_power_hold", 32'(m_if.power_total), 32'd360);

    // Single-cycle fault pulse during TRACK.
    do_reset();
    set_in(4'hF, 4'h0);
    tick(); tick();
    set_in(4'hF, 4'h1);
    tick();
    set_in(4'hF, 4'h0);
    check("pulse_enter", 32'(pst(0)), 32'd3);
    n = 0;
    while (pst(0) == 2'd3 && n < 40) begin
      n++;
      tick();
    end
    check("pulse_residency", n, 8);
    check("pulse_off", 32'(pst(0)), 32'd0);
    tick();
    check("pulse_retrack", 32'(pst(0)), 32'd1);
    check("pulse_angle_held", 32'(pang(0)), 32'd21278);

    // Fault held for 12 cycles.
    do_reset();
    set_in(4'hF, 4'h0);
    tick(); tick();
    set_in(4'hF, 4'h1);
    tick();
    cur = 3;
    check("held_enter", 32'(pst(0)), 32'd3);
    n = 0;
    while (pst(0) == 2'd3 && n < 40) begin
      n++;
      tick();
      cur++;
      if (cur == 14) set_in(4'hF, 4'h0);
    end
    check("held_residency", n, 16);
    check("held_off", 32'(pst(0)), 32'd0);
    tick();
    check("held_retrack", 32'(pst(0)), 32'd1);

    // Reset with panels in mixed TRACK/HARVEST/FAULT states.
    do_reset();
    set_in(4'hF, 4'h0);
    repeat (20) tick();
    set_in(4'b0111, 4'b0010);
    tick();
    set_in(4'hF, 4'h0);
    tick();
    check("mixed_state", 32'(m_if.state), 32'h0000_006E);
    rst = 1'b1;
    tick();
    check("rst_sun", 32'(m_if.sun), 32'd0);
    check("rst_state", 32'(m_if.state), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_angle%0d", i), 32'(pang(i)), 32'd16384);
    check("rst_energy", m_if.energy, 32'd0);
    check("rst_power", 32'(m_if.power_total), 32'd0);
    check("rst_sat_energy", 32'(s_if.energy), 32'd0);
    check("rst_wrap_angle", 32'(w_if.angle[15:0]), 32'd65000);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule : tb_solar_array
